// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; the MDU is the slave.
interface mdu_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUOP;
   logic        START;
   logic        BUSY;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOUT;

   // START is a one-cycle request sampled only while BUSY is low; there is no
   // back-pressure beyond BUSY, and results appear in HI/LO the cycle BUSY drops.
   modport master (output A, B, MDUOP, START, input BUSY, HI, LO, MDUOUT);
   modport slave  (input A, B, MDUOP, START, output BUSY, HI, LO, MDUOUT);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The arithmetic is evaluated in
// one step from latched operands and committed when the busy counter expires.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus,
   output logic  dbg_state_o
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic        is_signed, is_div;
   logic [63:0] a_ext, b_ext, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   assign is_signed = ~op_q[0];
   assign is_div    = op_q[1];

   // Signed multiply via sign extension: the low 64 bits of the wide product are exact.
   assign a_ext = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
   assign b_ext = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
   assign prod  = a_ext * b_ext;

   // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   assign a_neg = is_signed & a_q[31];
   assign b_neg = is_signed & b_q[31];
   assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
   assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
   assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
   assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               case (bus.MDUOP)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     op_d    = bus.MDUOP[1:0];
                     a_d     = bus.A;
                     b_d     = bus.B;
                     cnt_d   = bus.MDUOP[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     state_d = S_RUN;
                  end
                  3'd4:    hi_d = bus.A;
                  3'd5:    lo_d = bus.A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               if (!is_div) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (bus.MDUOP)
         3'd6:    bus.MDUOUT = hi_q;
         3'd7:    bus.MDUOUT = lo_q;
         default: bus.MDUOUT = 32'd0;
      endcase
   end

   assign bus.BUSY    = (state_q == S_RUN);
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign dbg_state_o = state_q;

endmodule
